avalon_pio_pulse_ctrl: RTL and testbench

- Parametrised Avalon-MM slave parallel-I/O controller for the Nios II system. Successor to the single-bit output PIO.
- Drives WIDTH output bits with direct, set and clear writes.
- Generates self-timed pulses on selected bits, e.g. for frame-clear or reset strobes into the video pipeline.
- Synchronises WIDTH input bits, captures their edges and raises a maskable interrupt to the CPU.

---
 rtl/avalon_pio_pulse_ctrl.sv | 141 ++++++++++++++
 tb/tb_avalon_pio_pulse_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_pulse_ctrl.sv
// Avalon-MM PIO controller: direct/set/clear outputs, self-timed pulses,
// synchronised inputs with edge capture and a maskable level interrupt.
module avalon_pio_pulse_ctrl #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned      EDGE_TYPE    = 0,
  parameter int unsigned      PULSE_CYCLES = 1,
  parameter int unsigned      SYNC_STAGES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int unsigned      CNT_W      = 8;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] pulse_mask;
  logic [CNT_W-1:0] pulse_cnt;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_term;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  // Bits above WIDTH-1 are deliberately ignored on write.
  assign unused_wd = ^writedata;

  // Output data register: direct load, write-1-to-set, write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        3'd0:    data_out <= wd;
        3'd1:    data_out <= data_out | wd;
        3'd2:    data_out <= data_out & ~wd;
        default: ;
      endcase
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_en && address == 3'd4 - 3'd1) begin
      irq_mask <= wd;
    end
  end

  // Pulse generator: trigger loads mask and count, mask drops as count hits 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_mask <= '0;
      pulse_cnt  <= '0;
    end else if (wr_en && address == 3'd5) begin
      pulse_mask <= wd;
      pulse_cnt  <= (wd == '0) ? '0 : PULSE_LOAD;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - CNT_W'(1);
      if (pulse_cnt == CNT_W'(1)) begin
        pulse_mask <= '0;
      end
    end
  end

  // Input synchroniser chain plus one-cycle delay for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_in <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_in <= sync_in;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Edge term selected at elaboration: rising, falling or any change.
  always_comb begin
    edge_term = '0;
    case (EDGE_TYPE)
      0:       edge_term = sync_in & ~prev_in;
      1:       edge_term = ~sync_in & prev_in;
      default: edge_term = sync_in ^ prev_in;
    endcase
  end

  // Edge capture: write-1-to-clear, a coincident new edge keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= '0;
    end else if (wr_en && address == 3'd4) begin
      edge_cap <= (edge_cap & ~wd) | edge_term;
    end else begin
      edge_cap <= edge_cap | edge_term;
    end
  end

  // Zero-wait-state read mux; unused upper bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = 32'(sync_in);
      3'd1:    readdata = 32'(data_out);
      3'd2:    readdata = 32'(data_out);
      3'd3:    readdata = 32'(irq_mask);
      3'd4:    readdata = 32'(edge_cap);
      3'd5:    readdata = 32'(pulse_mask);
      3'd6:    readdata = 32'(pulse_cnt);
      default: readdata = '0;
    endcase
  end

  assign out_port = data_out | pulse_mask;
  assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avalon_pio_pulse_ctrl.sv
// Self-checking bench for avalon_pio_pulse_ctrl: directed scenarios plus a
// randomized run against a cycle-indexed behavioural model.
module tb_avalon_pio_pulse_ctrl;

  localparam int unsigned  W  = 8;
  localparam int unsigned  PC = 4;
  localparam int unsigned  SS = 2;
  localparam int unsigned  ET = 0;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] in_port;
  logic [W-1:0] out_port;
  logic         irq;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: edge count, reset point, pulse end edge, input history per edge.
  int           cyc    = 0;
  int           rst_at = 0;
  int           m_end  = 0;
  logic [W-1:0] m_data, m_mask, m_cap, m_irqm;
  logic [W-1:0] hist [int];

  avalon_pio_pulse_ctrl #(
    .WIDTH(W), .RESET_VALUE(RV), .EDGE_TYPE(ET), .PULSE_CYCLES(PC), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // in_port value sampled at edge i; zero at or before the last reset.
  function automatic logic [W-1:0] h(input int i);
    if (i <= rst_at || !hist.exists(i)) return '0;
    return hist[i];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0:       return 32'(h(cyc - int'(SS) + 1));
      3'd1, 3'd2: return 32'(m_data);
      3'd3:       return 32'(m_irqm);
      3'd4:       return 32'(m_cap);
      3'd5:       return (cyc < m_end) ? 32'(m_mask) : 32'h0;
      3'd6:       return (cyc < m_end) ? 32'(m_end - cyc) : 32'h0;
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_out();
    return m_data | ((cyc < m_end) ? m_mask : '0);
  endfunction

  // One clock edge with the given bus inputs; model advanced at the edge.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    logic [W-1:0] sy, pv, e, clr, dw;
    chipselect = cs; write_n = wn; address = a; writedata = d;
    @(posedge clk);
    cyc++;
    hist[cyc] = in_port;
    sy = h(cyc - int'(SS));
    pv = h(cyc - int'(SS) - 1);
    e  = (ET == 0) ? (sy & ~pv) : (ET == 1) ? (~sy & pv) : (sy ^ pv);
    clr = '0;
    dw  = d[W-1:0];
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = dw;
        3'd1: m_data = m_data | dw;
        3'd2: m_data = m_data & ~dw;
        3'd3: m_irqm = dw;
        3'd4: clr = dw;
        3'd5: begin m_mask = dw; m_end = (dw != '0) ? cyc + int'(PC) : cyc; end
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr) | e;
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b0; write_n = 1'b1; address = a;
    #1;
  endtask

  // Completes a reset already asserted: one edge under reset, then release.
  task automatic finish_reset();
    chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
    @(posedge clk);
    cyc++;
    rst_at = cyc; m_end = cyc;
    m_data = RV; m_mask = '0; m_cap = '0; m_irqm = '0;
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_port = '0;
    finish_reset();
    n_checks++; if (out_port !== 8'hA5) $display("FAIL reset_out out_port=%h exp=%h", out_port, 8'hA5); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq irq=%b exp=0", irq); else n_pass++;
    rd(3'd4);
    n_checks++; if (readdata !== 32'h0) $display("FAIL reset_cap readdata=%h exp=0", readdata); else n_pass++;
    rd(3'd6);
    n_checks++; if (readdata !== 32'h0) $display("FAIL reset_cnt readdata=%h exp=0", readdata); else n_pass++;
  endtask

  task automatic test_data_writes();
    wr(3'd0, 32'h0F);
    n_checks++; if (out_port !== 8'h0F) $display("FAIL wr_direct out_port=%h exp=0f", out_port); else n_pass++;
    wr(3'd1, 32'h30);
    n_checks++; if (out_port !== 8'h3F) $display("FAIL wr_set out_port=%h exp=3f", out_port); else n_pass++;
    rd(3'd1);
    n_checks++; if (readdata !== 32'h3F) $display("FAIL rd_data1 readdata=%h exp=3f", readdata); else n_pass++;
    wr(3'd2, 32'h05);
    n_checks++; if (out_port !== 8'h3A) $display("FAIL wr_clr out_port=%h exp=3a", out_port); else n_pass++;
    rd(3'd2);
    n_checks++; if (readdata !== 32'h3A) $display("FAIL rd_data2 readdata=%h exp=3a", readdata); else n_pass++;
    wr(3'd0, 32'hFFFF_FF01);
    rd(3'd1);
    n_checks++; if (readdata !== 32'h01) $display("FAIL wr_upper readdata=%h exp=01", readdata); else n_pass++;
    step(1'b0, 1'b0, 3'd0, 32'hFF);
    n_checks++; if (out_port !== 8'h01) $display("FAIL no_cs out_port=%h exp=01", out_port); else n_pass++;
  endtask

  task automatic test_pulse();
    logic [W-1:0] e;
    wr(3'd5, 32'h80);
    n_checks++; if (out_port !== 8'h81) $display("FAIL pulse_start out_port=%h exp=81", out_port); else n_pass++;
    rd(3'd6);
    n_checks++; if (readdata !== 32'd4) $display("FAIL pulse_cnt4 readdata=%0d exp=4", readdata); else n_pass++;
    rd(3'd5);
    n_checks++; if (readdata !== 32'h80) $display("FAIL pulse_mask readdata=%h exp=80", readdata); else n_pass++;
    for (int k = 3; k >= 0; k--) begin
      idle();
      e = (k > 0) ? 8'h81 : 8'h01;
      n_checks++; if (out_port !== e) $display("FAIL pulse_out k=%0d out_port=%h exp=%h", k, out_port, e); else n_pass++;
      rd(3'd6);
      n_checks++; if (readdata !== 32'(k)) $display("FAIL pulse_cnt readdata=%0d exp=%0d", readdata, k); else n_pass++;
    end
  endtask

  task automatic test_retrigger();
    wr(3'd5, 32'h80);
    idle();
    idle();
    rd(3'd6);
    n_checks++; if (readdata !== 32'd2) $display("FAIL retrig_pre readdata=%0d exp=2", readdata); else n_pass++;
    wr(3'd5, 32'h02);
    n_checks++; if (out_port !== 8'h03) $display("FAIL retrig_out out_port=%h exp=03", out_port); else n_pass++;
    rd(3'd6);
    n_checks++; if (readdata !== 32'd4) $display("FAIL retrig_cnt readdata=%0d exp=4", readdata); else n_pass++;
    idle();
    wr(3'd5, 32'h0);
    n_checks++; if (out_port !== 8'h01) $display("FAIL cancel_out out_port=%h exp=01", out_port); else n_pass++;
    rd(3'd6);
    n_checks++; if (readdata !== 32'd0) $display("FAIL cancel_cnt readdata=%0d exp=0", readdata); else n_pass++;
  endtask

  task automatic test_edge_irq();
    wr(3'd3, 32'h01);
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_idle irq=%b exp=0", irq); else n_pass++;
    in_port = 8'h01;
    idle();
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_e1 irq=%b exp=0", irq); else n_pass++;
    idle();
    rd(3'd0);
    n_checks++; if (readdata !== 32'h01) $display("FAIL sync_in readdata=%h exp=01", readdata); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL irq_e2 irq=%b exp=0", irq); else n_pass++;
    idle();
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_e3 irq=%b exp=1", irq); else n_pass++;
    rd(3'd4);
    n_checks++; if (readdata !== 32'h01) $display("FAIL cap_set readdata=%h exp=01", readdata); else n_pass++;
    wr(3'd4, 32'h01);
    n_checks++; if (irq !== 1'b0) $display("FAIL cap_clr_irq irq=%b exp=0", irq); else n_pass++;
    in_port = 8'h00;
    repeat (4) idle();
    rd(3'd4);
    n_checks++; if (readdata !== 32'h0) $display("FAIL fall_ignored readdata=%h exp=0", readdata); else n_pass++;
    in_port = 8'h01;
    repeat (3) idle();
    n_checks++; if (irq !== 1'b1) $display("FAIL irq_again irq=%b exp=1", irq); else n_pass++;
    wr(3'd3, 32'h0);
    n_checks++; if (irq !== 1'b0) $display("FAIL mask_clr_irq irq=%b exp=0", irq); else n_pass++;
    wr(3'd3, 32'h01);
    n_checks++; if (irq !== 1'b1) $display("FAIL mask_set_irq irq=%b exp=1", irq); else n_pass++;
  endtask

  task automatic test_set_wins();
    in_port = 8'h00;
    repeat (4) idle();
    in_port = 8'h01;
    idle();
    idle();
    wr(3'd4, 32'h01);
    rd(3'd4);
    n_checks++; if (readdata !== 32'h01) $display("FAIL set_wins readdata=%h exp=01", readdata); else n_pass++;
    n_checks++; if (irq !== 1'b1) $display("FAIL set_wins_irq irq=%b exp=1", irq); else n_pass++;
    wr(3'd4, 32'h01);
    rd(3'd4);
    n_checks++; if (readdata !== 32'h0) $display("FAIL clr_after readdata=%h exp=0", readdata); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    wr(3'd5, 32'hF0);
    idle();
    n_checks++; if (out_port !== 8'hF1) $display("FAIL mid_pulse out_port=%h exp=f1", out_port); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (out_port !== 8'hA5) $display("FAIL async_rst out_port=%h exp=a5", out_port); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL async_rst_irq irq=%b exp=0", irq); else n_pass++;
    finish_reset();
    rd(3'd6);
    n_checks++; if (readdata !== 32'h0) $display("FAIL rst_cnt readdata=%0d exp=0", readdata); else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0]  a, ra;
    logic [31:0] d, e;
    logic        cs, wn;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 1) != 0);
      a  = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      step(cs, wn, a, d);
      n_checks++; if (out_port !== exp_out()) $display("FAIL rnd_out n=%0d out_port=%h exp=%h", n, out_port, exp_out()); else n_pass++;
      n_checks++; if (irq !== |(m_cap & m_irqm)) $display("FAIL rnd_irq n=%0d irq=%b exp=%b", n, irq, |(m_cap & m_irqm)); else n_pass++;
      ra = 3'($urandom_range(0, 7));
      rd(ra);
      e = exp_rd(ra);
      n_checks++; if (readdata !== e) $display("FAIL rnd_rd n=%0d addr=%0d readdata=%h exp=%h", n, ra, readdata, e); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
    writedata = 32'h0; in_port = '0;
    m_data = RV; m_mask = '0; m_cap = '0; m_irqm = '0;
    test_reset();
    test_data_writes();
    test_pulse();
    test_retrigger();
    test_edge_irq();
    test_set_wins();
    test_reset_mid_pulse();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
